// File: rtl/la_xtalctrl_pkg.sv
// rtl/la_xtalctrl_pkg.sv - shared types and constants for the crystal start-up controller
package la_xtalctrl_pkg;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_START   = 3'd1,
        ST_MEASURE = 3'd2,
        ST_READY   = 3'd3,
        ST_FAULT   = 3'd4
    } xstate_t;

    // Bit positions inside the la_ioxtal cfg bus
    localparam int CFG_OSCEN   = 0;
    localparam int CFG_DRV_LSB = 1;
    localparam int CFG_DRV_MSB = 3;
    localparam int CFG_BYPASS  = 4;

    localparam logic [2:0] DRIVE_MAX = 3'd7;

endpackage

// File: rtl/la_dsync.sv
// rtl/la_dsync.sv - two-stage synchronizer for a single asynchronous bit
module la_dsync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [1:0] sync_q;

    // Shift the asynchronous input through two flops to settle metastability
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], din};
        end
    end

    assign dout = sync_q[1];

endmodule

// File: rtl/la_xtalctrl_timer.sv
// rtl/la_xtalctrl_timer.sv - loadable down-counter shared by start-up wait and measurement window
module la_xtalctrl_timer #(
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [CNTW-1:0] load_val,
    output logic            zero
);

    logic [CNTW-1:0] cnt_q;

    // Load takes priority; otherwise count down and hold at zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNTW'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/la_xtalctrl.sv
// rtl/la_xtalctrl.sv - start-up, drive escalation and supervision of the la_ioxtal oscillator
module la_xtalctrl
    import la_xtalctrl_pkg::*;
#(
    parameter int CFGW = 16,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            bypass,
    input  logic [2:0]      drive_init,
    input  logic [CNTW-1:0] startup_cycles,
    input  logic [CNTW-1:0] window_cycles,
    input  logic [CNTW-1:0] min_edges,
    input  logic [CNTW-1:0] max_edges,
    input  logic            xtal_z,
    output logic [CFGW-1:0] cfg,
    output logic            ready,
    output logic            fault,
    output logic            lost,
    output logic [2:0]      drive,
    output logic [2:0]      state
);

    xstate_t         state_q;
    xstate_t         state_nxt;
    logic            bypass_q;
    logic [CNTW-1:0] min_q;
    logic [CNTW-1:0] max_q;
    logic [CNTW-1:0] edge_cnt_q;
    logic [CNTW-1:0] edge_total;
    logic [CNTW-1:0] win_load;
    logic [2:0]      drive_q;
    logic            lost_q;
    logic            xtal_sync;
    logic            xtal_hist_q;
    logic            xtal_edge;
    logic            tmr_load;
    logic            tmr_zero;
    logic [CNTW-1:0] tmr_val;
    logic            in_window;
    logic            win_end;
    logic            win_pass;
    logic            start_run;

    la_dsync u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (xtal_z),
        .dout  (xtal_sync)
    );

    la_xtalctrl_timer #(.CNTW(CNTW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // History flop behind the synchronizer for rising-edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xtal_hist_q <= 1'b0;
        end else begin
            xtal_hist_q <= xtal_sync;
        end
    end

    assign xtal_edge  = xtal_sync & ~xtal_hist_q;
    assign in_window  = (state_q == ST_MEASURE) || (state_q == ST_READY);
    assign win_end    = in_window && tmr_zero;
    assign start_run  = (state_q == ST_OFF) && en;
    // The final window cycle's edge is folded in here so the decision sees it
    assign edge_total = (xtal_edge && (edge_cnt_q != '1)) ? edge_cnt_q + CNTW'(1) : edge_cnt_q;
    assign win_pass   = (edge_total >= min_q) && (edge_total <= max_q);
    // A window of N cycles loads N-1 because the zero cycle is itself counted
    assign win_load   = (window_cycles == '0) ? '0 : window_cycles - CNTW'(1);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_OFF;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state and timer load selection
    always_comb begin
        state_nxt = state_q;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        if (!en) begin
            state_nxt = ST_OFF;
            tmr_load  = 1'b1;
        end else begin
            case (state_q)
                ST_OFF: begin
                    tmr_load = 1'b1;
                    if (bypass) begin
                        state_nxt = ST_MEASURE;
                        tmr_val   = win_load;
                    end else begin
                        state_nxt = ST_START;
                        tmr_val   = startup_cycles;
                    end
                end
                ST_START: begin
                    if (tmr_zero) begin
                        state_nxt = ST_MEASURE;
                        tmr_load  = 1'b1;
                        tmr_val   = win_load;
                    end
                end
                ST_MEASURE, ST_READY: begin
                    if (tmr_zero) begin
                        tmr_load = 1'b1;
                        if (win_pass) begin
                            state_nxt = ST_READY;
                            tmr_val   = win_load;
                        end else if ((state_q == ST_READY) || (drive_q != DRIVE_MAX)) begin
                            state_nxt = bypass_q ? ST_MEASURE : ST_START;
                            tmr_val   = bypass_q ? win_load : startup_cycles;
                        end else begin
                            state_nxt = ST_FAULT;
                        end
                    end
                end
                ST_FAULT: begin
                    state_nxt = ST_FAULT;
                end
                default: begin
                    state_nxt = ST_OFF;
                end
            endcase
        end
    end

    // Capture the run configuration when leaving OFF
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bypass_q <= 1'b0;
            min_q    <= '0;
            max_q    <= '0;
        end else if (start_run) begin
            bypass_q <= bypass;
            min_q    <= min_edges;
            max_q    <= max_edges;
        end
    end

    // Drive code: seeded on start, stepped up after a failed initial qualification
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drive_q <= 3'd0;
        end else if (!en) begin
            drive_q <= 3'd0;
        end else if (start_run) begin
            drive_q <= drive_init;
        end else if ((state_q == ST_MEASURE) && win_end && !win_pass && (drive_q != DRIVE_MAX)) begin
            drive_q <= drive_q + 3'd1;
        end
    end

    // Loss-of-clock flag, sticky until the controller is disabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lost_q <= 1'b0;
        end else if (!en) begin
            lost_q <= 1'b0;
        end else if ((state_q == ST_READY) && win_end && !win_pass) begin
            lost_q <= 1'b1;
        end
    end

    // Edge counter restarts at every window boundary and outside windows
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_cnt_q <= '0;
        end else if (!en || !in_window || win_end) begin
            edge_cnt_q <= '0;
        end else begin
            edge_cnt_q <= edge_total;
        end
    end

    // Pad configuration and status decoded from the current state
    always_comb begin
        cfg   = '0;
        ready = 1'b0;
        fault = 1'b0;
        case (state_q)
            ST_START, ST_MEASURE, ST_READY: begin
                cfg[CFG_DRV_MSB:CFG_DRV_LSB] = drive_q;
                if (bypass_q) begin
                    cfg[CFG_BYPASS] = 1'b1;
                end else begin
                    cfg[CFG_OSCEN] = 1'b1;
                end
                ready = (state_q == ST_READY);
            end
            ST_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                cfg = '0;
            end
        endcase
    end

    assign lost  = lost_q;
    assign drive = drive_q;
    assign state = state_q;

endmodule
